// File: rtl/parking_pkg.sv
// Shared types and constants for the parking gate arbiter and the occupancy counter.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    EXIT  = 2'd2,
    CLEAR = 2'd3
  } gate_state_t;

  typedef enum logic {
    DIR_ENTER = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  localparam int DEFAULT_CAPACITY = 16;
  localparam int COUNT_W          = 5;

  // Bits needed to hold (cycles-1); never narrower than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Gate arbiter bus: sensor requests and counter pulses in, grants and status out.
interface parking_gate_arbiter_if;
  import parking_pkg::*;

  // Requests are levels held while a car waits; car_in/car_out are single-cycle
  // pulses; grants are levels that stay high until released by the arbiter.
  logic               req_enter;
  logic               req_exit;
  logic               car_in;
  logic               car_out;
  logic [COUNT_W-1:0] count;
  logic               grant_enter;
  logic               grant_exit;
  logic               gate_open;
  logic               full;
  logic               timeout;
  gate_state_t        state;

  modport master (
    output req_enter, req_exit, car_in, car_out, count,
    input  grant_enter, grant_exit, gate_open, full, timeout, state
  );

  modport slave (
    input  req_enter, req_exit, car_in, car_out, count,
    output grant_enter, grant_exit, gate_open, full, timeout, state
  );

endinterface

// File: rtl/gate_timer.sv
// Loadable down-counter; done is high while the count sits at zero (no wrap).
module gate_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Single-lane gate arbiter: grants entry or exit, waits for pass/drop/timeout, then
// holds the gate closed for a clearance interval before arbitrating again.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = DEFAULT_CAPACITY,
  parameter int TIMEOUT      = 8,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  parking_gate_arbiter_if.slave bus
);

  localparam int GW = timer_width(TIMEOUT);
  localparam int CW = timer_width(CLEAR_CYCLES);
  localparam logic [GW-1:0] GRANT_LOAD = GW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

  gate_state_t state, next_state;
  dir_t        last_grant, next_last;
  logic        timeout_q, timeout_next;
  logic        grant_load, clear_load;
  logic        grant_done, clear_done;
  logic        full, enter_ok, exit_ok;

  assign full     = int'(bus.count) >= CAPACITY;
  assign enter_ok = bus.req_enter & ~full;
  assign exit_ok  = bus.req_exit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= DIR_EXIT;
      timeout_q  <= 1'b0;
    end else begin
      state      <= next_state;
      last_grant <= next_last;
      timeout_q  <= timeout_next;
    end
  end

  // Within a grant: pass pulse beats request drop, which beats the timer.
  always_comb begin
    next_state   = state;
    next_last    = last_grant;
    timeout_next = 1'b0;
    grant_load   = 1'b0;
    case (state)
      IDLE: begin
        if (enter_ok && (!exit_ok || last_grant == DIR_EXIT)) begin
          next_state = ENTER;
          next_last  = DIR_ENTER;
          grant_load = 1'b1;
        end else if (exit_ok) begin
          next_state = EXIT;
          next_last  = DIR_EXIT;
          grant_load = 1'b1;
        end
      end
      ENTER: begin
        if (bus.car_in || !bus.req_enter) begin
          next_state = CLEAR;
        end else if (grant_done) begin
          next_state   = CLEAR;
          timeout_next = 1'b1;
        end
      end
      EXIT: begin
        if (bus.car_out || !bus.req_exit) begin
          next_state = CLEAR;
        end else if (grant_done) begin
          next_state   = CLEAR;
          timeout_next = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign clear_load = (next_state == CLEAR) && (state != CLEAR);

  gate_timer #(.W(GW)) u_grant_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (grant_load),
    .en       ((state == ENTER) || (state == EXIT)),
    .load_val (GRANT_LOAD),
    .done     (grant_done)
  );

  gate_timer #(.W(CW)) u_clear_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (clear_load),
    .en       (state == CLEAR),
    .load_val (CLEAR_LOAD),
    .done     (clear_done)
  );

  assign bus.grant_enter = (state == ENTER);
  assign bus.grant_exit  = (state == EXIT);
  assign bus.gate_open   = (state == ENTER) || (state == EXIT);
  assign bus.full        = full;
  assign bus.timeout     = timeout_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed scenarios for the parking gate arbiter with a per-cycle expected-output queue.
module tb_parking_gate_arbiter;
  import parking_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  parking_gate_arbiter_if bus();

  parking_gate_arbiter #(
    .CAPACITY     (16),
    .TIMEOUT      (8),
    .CLEAR_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [6:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packed view: {state[1:0], grant_enter, grant_exit, gate_open, full, timeout}
  function automatic logic [6:0] ev(gate_state_t s, logic ge, logic gx, logic go,
                                    logic f, logic to);
    return {s, ge, gx, go, f, to};
  endfunction

  task automatic step(input string tag, input logic [6:0] e);
    logic [6:0] got;
    logic [6:0] want;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got  = {bus.state, bus.grant_enter, bus.grant_exit, bus.gate_open, bus.full, bus.timeout};
    want = exp_q.pop_front();
    check(tag, 32'(got), 32'(want));
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_enter = 1'b0;
    bus.req_exit  = 1'b0;
    bus.car_in    = 1'b0;
    bus.car_out   = 1'b0;
    bus.count     = '0;

    step("reset", ev(IDLE, 0, 0, 0, 0, 0));
    reset = 1'b0;
    step("reset_idle", ev(IDLE, 0, 0, 0, 0, 0));

    // Single entry with pass pulse
    bus.count = 5'd3; bus.req_enter = 1'b1;
    step("t1_grant", ev(ENTER, 1, 0, 1, 0, 0));
    bus.car_in = 1'b1;
    step("t1_clear1", ev(CLEAR, 0, 0, 0, 0, 0));
    bus.car_in = 1'b0; bus.req_enter = 1'b0;
    step("t1_clear2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t1_idle", ev(IDLE, 0, 0, 0, 0, 0));

    // Alternation under contention
    reset = 1'b1;
    step("t2_reset", ev(IDLE, 0, 0, 0, 0, 0));
    reset = 1'b0; bus.req_enter = 1'b1; bus.req_exit = 1'b1;
    step("t2_enter_first", ev(ENTER, 1, 0, 1, 0, 0));
    bus.car_in = 1'b1;
    step("t2_clear_a1", ev(CLEAR, 0, 0, 0, 0, 0));
    bus.car_in = 1'b0;
    step("t2_clear_a2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t2_idle_a", ev(IDLE, 0, 0, 0, 0, 0));
    step("t2_exit", ev(EXIT, 0, 1, 1, 0, 0));
    bus.car_out = 1'b1;
    step("t2_clear_b1", ev(CLEAR, 0, 0, 0, 0, 0));
    bus.car_out = 1'b0;
    step("t2_clear_b2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t2_idle_b", ev(IDLE, 0, 0, 0, 0, 0));
    step("t2_enter_again", ev(ENTER, 1, 0, 1, 0, 0));
    bus.req_enter = 1'b0; bus.req_exit = 1'b0;
    step("t2_drop", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t2_clear_c2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t2_idle_c", ev(IDLE, 0, 0, 0, 0, 0));

    // Lot full refuses entry but not exit
    bus.count = 5'd16; bus.req_enter = 1'b1;
    for (int i = 0; i < 10; i++) step("t3_refuse", ev(IDLE, 0, 0, 0, 1, 0));
    bus.req_exit = 1'b1;
    step("t3_exit", ev(EXIT, 0, 1, 1, 1, 0));
    bus.req_exit = 1'b0; bus.req_enter = 1'b0;
    step("t3_clear1", ev(CLEAR, 0, 0, 0, 1, 0));
    step("t3_clear2", ev(CLEAR, 0, 0, 0, 1, 0));
    step("t3_idle", ev(IDLE, 0, 0, 0, 1, 0));
    bus.count = 5'd15; #1;
    check("full_15", 32'(bus.full), 32'd0);
    bus.count = 5'd20; #1;
    check("full_20", 32'(bus.full), 32'd1);
    bus.count = 5'd0; #1;
    check("full_0", 32'(bus.full), 32'd0);

    // Grant timeout after 8 cycles without a pass
    bus.count = 5'd3; bus.req_enter = 1'b1;
    for (int i = 0; i < 8; i++) step("t4_hold", ev(ENTER, 1, 0, 1, 0, 0));
    step("t4_timeout", ev(CLEAR, 0, 0, 0, 0, 1));
    bus.req_enter = 1'b0;
    step("t4_clear2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t4_idle", ev(IDLE, 0, 0, 0, 0, 0));

    // Reset mid-grant restores entry priority
    bus.req_enter = 1'b1;
    step("t5_enter", ev(ENTER, 1, 0, 1, 0, 0));
    step("t5_enter2", ev(ENTER, 1, 0, 1, 0, 0));
    reset = 1'b1;
    step("t5_reset", ev(IDLE, 0, 0, 0, 0, 0));
    reset = 1'b0; bus.req_exit = 1'b1;
    step("t5_enter_first", ev(ENTER, 1, 0, 1, 0, 0));
    bus.req_enter = 1'b0; bus.req_exit = 1'b0;
    step("t5_drop", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t5_clear2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t5_idle", ev(IDLE, 0, 0, 0, 0, 0));

    // Exit at count 0, car_in ignored, request drop closes without timeout
    bus.count = 5'd0; bus.req_exit = 1'b1;
    step("t6_exit", ev(EXIT, 0, 1, 1, 0, 0));
    bus.car_in = 1'b1;
    step("t6_car_in_ignored", ev(EXIT, 0, 1, 1, 0, 0));
    bus.car_in = 1'b0;
    step("t6_hold", ev(EXIT, 0, 1, 1, 0, 0));
    bus.req_exit = 1'b0;
    step("t6_drop", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t6_clear2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t6_idle", ev(IDLE, 0, 0, 0, 0, 0));

    // Pass on the final timer cycle is a pass, not a timeout
    bus.req_exit = 1'b1;
    for (int i = 0; i < 8; i++) step("t7_hold", ev(EXIT, 0, 1, 1, 0, 0));
    bus.car_out = 1'b1;
    step("t7_pass_last", ev(CLEAR, 0, 0, 0, 0, 0));
    bus.car_out = 1'b0; bus.req_exit = 1'b0;
    step("t7_clear2", ev(CLEAR, 0, 0, 0, 0, 0));
    step("t7_idle", ev(IDLE, 0, 0, 0, 0, 0));

    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
